gray_frame_arbiter: RTL
=======================

GRAY_FRAME_ARBITER -- requirements
Module: gray_frame_arbiter

Interface
REQ-001 Parameter: WIDTH, default 720, pixels per line.
REQ-002 Parameter: HEIGHT, default 540, lines per frame; FRAME = WIDTH*HEIGHT pixels.
REQ-003 The block SHALL use reset reset, asynchronous, active-high; clock clock.
REQ-004 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- enable  in  1  level; permits new frame grants
- in0_rd_en  out  1  read strobe, RGB FIFO 0
- in0_empty  in  1  FIFO 0 empty
- in0_dout  in  24  FIFO 0 pixel {R,G,B}
- in1_rd_en  out  1  read strobe, RGB FIFO 1
- in1_empty  in  1  FIFO 1 empty
- in1_dout  in  24  FIFO 1 pixel {R,G,B}
- gs_rd_en  in  1  read strobe from downstream grayscale stage
- gs_empty  out  1  muxed empty to grayscale stage
- gs_dout  out  24  muxed pixel to grayscale stage
- src  out  1  granted source index
- busy  out  1  high in RUN and DONE
- frame_done  out  1  one-cycle pulse at end of frame
- frame_cnt  out  16  completed frames, wraps

Function
REQ-005 FSM states SHALL be IDLE, SEL, RUN, DONE.
REQ-006 IDLE: enable=1 -> SEL next cycle; otherwise stay.
REQ-007 SEL: enable=0 -> IDLE; else requester N is active when inN_empty=0; neither active -> stay in SEL.
REQ-008 SEL arbitration SHALL be round-robin on last_grant: both active -> grant the index != last_grant; one active -> grant it; on grant, src<=index, last_grant<=index, pix_cnt<=0, -> RUN.
REQ-009 RUN mux: gs_empty=in[src]_empty, gs_dout=in[src]_dout, in[src]_rd_en=gs_rd_en AND NOT in[src]_empty; other FIFO rd_en=0.
REQ-010 Outside RUN: gs_empty=1, gs_dout=0, in0_rd_en=in1_rd_en=0; gs_rd_en ignored.
REQ-011 Accepted read = RUN AND gs_rd_en AND NOT gs_empty; pix_cnt SHALL increment by 1 per accepted read, width clog2(FRAME).
REQ-012 Accepted read with pix_cnt=FRAME-1 -> DONE next cycle; pix_cnt returns to 0; no read beyond FRAME pixels per grant.
REQ-013 Grant SHALL NOT change within a frame; other source's activity and enable=0 during RUN are ignored until the frame completes.
REQ-014 Source FIFO empty mid-frame SHALL stall (gs_empty=1, count held), never forfeit the grant.
REQ-015 DONE: lasts exactly one cycle; frame_done=1; frame_cnt increments (16-bit wrap 0xFFFF->0x0000); -> SEL.
REQ-016 frame_done, busy, gs_empty, gs_dout, rd_en SHALL be combinational from state/registers and inputs as above; src registered, held through DONE.
REQ-017 Latency: first in[src]_rd_en possible in the cycle after the SEL grant cycle; frame_done one cycle after last accepted read.

Reset
REQ-018 reset=1 SHALL force state=IDLE, src=0, last_grant=1 (first contended grant goes to source 0), pix_cnt=0, frame_cnt=0, frame_done=0, busy=0, gs_empty=1, gs_dout=0, in0_rd_en=in1_rd_en=0.
REQ-019 Reset asserted mid-frame SHALL abort the frame immediately with no frame_done pulse; partial count discarded.

Verification (WIDTH=4, HEIGHT=2, FRAME=8)
REQ-020 Both FIFOs non-empty, enable=1, gs_rd_en=1 continuous -> src 0 for 8 reads, frame_done pulse, src 1 for 8 reads, alternate; frame_cnt=2 after two frames.
REQ-021 Only FIFO 1 non-empty for three frames -> src=1 each frame, in0_rd_en never asserted, frame_cnt=3.
REQ-022 FIFO 0 empties after pixel 5 for 10 cycles while FIFO 1 full -> gs_empty=1, pix_cnt held at 5, src stays 0; frame completes after 8 total reads from FIFO 0.
REQ-023 enable dropped at pixel 3 -> frame completes (8 reads), frame_done pulses, FSM SEL->IDLE, no further reads.
REQ-024 reset pulsed at pixel 6 -> all outputs at reset values next cycle, frame_cnt=0, no frame_done; after release with enable=1, first contended grant goes to src 0.
REQ-025 frame_cnt preloaded via 65535 frames (or force) -> next frame_done wraps frame_cnt to 0.

Source files
------------

// File: rtl/gray_frame_arbiter.sv
// Round-robin arbiter that hands whole frames from one of two RGB FIFOs to a
// downstream grayscale stage; the grant is held until FRAME pixels are read.
module gray_frame_arbiter #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 540
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  output logic        in0_rd_en,
  input  logic        in0_empty,
  input  logic [23:0] in0_dout,
  output logic        in1_rd_en,
  input  logic        in1_empty,
  input  logic [23:0] in1_dout,
  input  logic        gs_rd_en,
  output logic        gs_empty,
  output logic [23:0] gs_dout,
  output logic        src,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int FRAME = WIDTH * HEIGHT;
  localparam int CNT_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME - 1);

  typedef enum logic [1:0] {IDLE, SEL, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic             src_q, src_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             sel_empty;
  logic [23:0]      sel_dout;
  logic             accept;
  logic             act0, act1;

  // last_grant resets to 1 so the first contended grant goes to source 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign sel_empty = src_q ? in1_empty : in0_empty;
  assign sel_dout  = src_q ? in1_dout  : in0_dout;
  assign act0      = ~in0_empty;
  assign act1      = ~in1_empty;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    pix_cnt_d    = pix_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    gs_empty     = 1'b1;
    gs_dout      = '0;
    in0_rd_en    = 1'b0;
    in1_rd_en    = 1'b0;
    busy         = 1'b0;
    frame_done   = 1'b0;
    accept       = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = SEL;
      end
      SEL: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (act0 || act1) begin
          // Contention goes to whichever source did not win last time.
          if (act0 && act1) src_d = ~last_grant_q;
          else              src_d = act1;
          last_grant_d = src_d;
          pix_cnt_d    = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        busy      = 1'b1;
        gs_empty  = sel_empty;
        gs_dout   = sel_dout;
        accept    = gs_rd_en & ~sel_empty;
        in0_rd_en = accept & ~src_q;
        in1_rd_en = accept & src_q;
        if (accept) begin
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            state_d   = DONE;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        busy        = 1'b1;
        frame_done  = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  assign src       = src_q;
  assign frame_cnt = frame_cnt_q;

endmodule
